// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter onto one synchronous single-port memory (option: ARB_MISALIGN_TRAP_EN)
module unified_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_size,
    input  logic        dm_unsigned,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [31:0] dm_rdata,
    output logic        dm_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]  state;
    logic [3:0]  starve_cnt;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [31:0] if_rdata_q;
    logic [31:0] dm_rdata_q;
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        err_q;

    logic        trap;
    logic [31:0] eff_addr;
    logic        dm_issue;
    logic [3:0]  be_raw;
    logic [31:0] wdata_lanes;
    logic        load_resp;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic        unused_ok;

    assign unused_ok = ^if_addr[1:0];

`ifdef ARB_MISALIGN_TRAP_EN
    // Misaligned accesses are flagged and kept off the memory bus
    always_comb begin
        trap     = (dm_size == 2'b01 && dm_addr[0]) || (dm_size[1] && dm_addr[1:0] != 2'b00);
        eff_addr = dm_addr;
    end
`else
    // Misaligned accesses are silently rounded down to natural alignment
    always_comb begin
        trap     = 1'b0;
        eff_addr = dm_addr;
        if (dm_size[1])
            eff_addr[1:0] = 2'b00;
        else if (dm_size == 2'b01)
            eff_addr[0] = 1'b0;
    end
`endif

    // Data wins by default; fetch wins once the data side has had its run
    always_comb begin
        if_gnt = rst & if_req & (~dm_req | (starve_cnt == STARVE_LIM));
        dm_gnt = rst & dm_req & ~if_gnt;
    end

    // Store lane steering: byte enables and replicated write data
    always_comb begin
        be_raw      = 4'b1111;
        wdata_lanes = dm_wdata;
        if (dm_size == 2'b00) begin
            be_raw      = 4'b0001 << eff_addr[1:0];
            wdata_lanes = {4{dm_wdata[7:0]}};
        end else if (dm_size == 2'b01) begin
            be_raw      = 4'b0011 << eff_addr[1:0];
            wdata_lanes = {2{dm_wdata[15:0]}};
        end
    end

    // Memory-side drive; address and write data hold their last issued values when idle
    always_comb begin
        dm_issue  = dm_gnt & ~trap;
        mem_we    = dm_issue & dm_we;
        mem_be    = mem_we ? be_raw : 4'b0000;
        mem_wdata = mem_we ? wdata_lanes : last_wdata;
        if (if_gnt)
            mem_addr = {if_addr[31:2], 2'b00};
        else if (dm_issue)
            mem_addr = {eff_addr[31:2], 2'b00};
        else
            mem_addr = last_addr;
    end

    // Load data alignment and sign/zero extension from the recorded access attributes
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        if (size_q == 2'b00)
            load_ext = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        else if (size_q == 2'b01)
            load_ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        else
            load_ext = shifted;
    end

    // Response side: the state register says which port owns this cycle's read word
    always_comb begin
        if_valid  = (state == FETCH);
        dm_valid  = (state == DATA);
        load_resp = dm_valid & ~we_q & ~err_q;
        dm_err    = dm_valid & err_q;
        if_rdata  = if_valid ? mem_rdata : if_rdata_q;
        dm_rdata  = load_resp ? load_ext : dm_rdata_q;
    end

    // Outstanding-access tracking, starvation counter and held output values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            last_addr  <= 32'h0;
            last_wdata <= 32'h0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (if_gnt)
                state <= FETCH;
            else if (dm_gnt)
                state <= DATA;
            else
                state <= IDLE;

            if (if_gnt)
                starve_cnt <= 4'd0;
            else if (dm_gnt && if_req && starve_cnt < STARVE_LIM)
                starve_cnt <= starve_cnt + 4'd1;

            if (if_gnt || dm_issue)
                last_addr <= mem_addr;
            if (mem_we)
                last_wdata <= mem_wdata;
            if (if_valid)
                if_rdata_q <= mem_rdata;
            if (load_resp)
                dm_rdata_q <= load_ext;

            if (dm_gnt) begin
                lane_q <= eff_addr[1:0];
                size_q <= dm_size;
                uns_q  <= dm_unsigned;
                we_q   <= dm_we;
                err_q  <= trap;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [1:0]  dm_size;
    logic        dm_unsigned;
    logic        dm_gnt;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int          n_tests;
    int          n_fail;

    unified_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_valid(if_valid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_size(dm_size), .dm_unsigned(dm_unsigned), .dm_gnt(dm_gnt),
        .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory model with byte-enabled writes; reset reloads the program words
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'h00A00093;
            mem[8'h41] <= 32'h00B00113;
            mem_rdata  <= 32'h0;
        end else begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dm_op(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [3:0] ebe, input logic [31:0] emaddr,
                         input logic [31:0] ewdata, input logic [31:0] erdata, input logic eerr);
        tick();
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_size = size;
        dm_unsigned = uns; dm_wdata = wdata;
        #1;
        check({tag, "_gnt"}, {31'h0, dm_gnt}, 32'd1);
        check({tag, "_we"}, {31'h0, mem_we}, {31'h0, (ebe != 4'b0000)});
        check({tag, "_be"}, {28'h0, mem_be}, {28'h0, ebe});
        check({tag, "_maddr"}, mem_addr, emaddr);
        if (we && ebe != 4'b0000) check({tag, "_wdata"}, mem_wdata, ewdata);
        tick();
        dm_req = 1'b0;
        #1;
        check({tag, "_valid"}, {31'h0, dm_valid}, 32'd1);
        check({tag, "_err"}, {31'h0, dm_err}, {31'h0, eerr});
        check({tag, "_rdata"}, dm_rdata, erdata);
    endtask

    logic [1:0]  pat [10];
    logic [31:0] last_rd;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        dm_size = 2'b10; dm_unsigned = 1'b0;
        pat = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

        // Reset state with both requests asserted
        #12;
        check("rst_if_gnt", {31'h0, if_gnt}, 32'd0);
        check("rst_dm_gnt", {31'h0, dm_gnt}, 32'd0);
        check("rst_valids", {30'h0, if_valid, dm_valid}, 32'd0);
        check("rst_err_we", {30'h0, dm_err, mem_we}, 32'd0);
        check("rst_be", {28'h0, mem_be}, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_mwdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        if_req = 1'b0; dm_req = 1'b0;
        tick();
        rst = 1'b1;

        // Single fetch: grant at N, data at N+1, held afterwards
        tick();
        if_req = 1'b1; if_addr = 32'h103;
        #1;
        check("fetch_gnt", {31'h0, if_gnt}, 32'd1);
        check("fetch_maddr", mem_addr, 32'h100);
        check("fetch_be", {27'h0, mem_we, mem_be}, 32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("fetch_valid", {31'h0, if_valid}, 32'd1);
        check("fetch_rdata", if_rdata, 32'h00A00093);
        tick();
        #1;
        check("fetch_valid_end", {31'h0, if_valid}, 32'd0);
        check("fetch_rdata_hold", if_rdata, 32'h00A00093);
        check("fetch_maddr_hold", mem_addr, 32'h100);

        // Byte store then signed/unsigned byte loads
        dm_op("sb_203", 1'b1, 32'h203, 2'b00, 1'b0, 32'h000000AB, 4'b1000, 32'h200, 32'hABABABAB, 32'h0, 1'b0);
        dm_op("lb_203", 1'b0, 32'h203, 2'b00, 1'b0, 32'h0, 4'b0000, 32'h200, 32'h0, 32'hFFFFFFAB, 1'b0);
        dm_op("lbu_203", 1'b0, 32'h203, 2'b00, 1'b1, 32'h0, 4'b0000, 32'h200, 32'h0, 32'h000000AB, 1'b0);

        // Misaligned word load
`ifdef ARB_MISALIGN_TRAP_EN
        dm_op("lw_202", 1'b0, 32'h202, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h200, 32'h0, 32'h000000AB, 1'b1);
        last_rd = 32'h000000AB;
`else
        dm_op("lw_202", 1'b0, 32'h202, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h200, 32'h0, 32'hAB000000, 1'b0);
        last_rd = 32'hAB000000;
`endif

        // Halfword and word traffic
        dm_op("sh_206", 1'b1, 32'h206, 2'b01, 1'b0, 32'h00008001, 4'b1100, 32'h204, 32'h80018001, last_rd, 1'b0);
        dm_op("lh_206", 1'b0, 32'h206, 2'b01, 1'b0, 32'h0, 4'b0000, 32'h204, 32'h0, 32'hFFFF8001, 1'b0);
        dm_op("lhu_206", 1'b0, 32'h206, 2'b01, 1'b1, 32'h0, 4'b0000, 32'h204, 32'h0, 32'h00008001, 1'b0);
        dm_op("lw_204", 1'b0, 32'h204, 2'b10, 1'b0, 32'h0, 4'b0000, 32'h204, 32'h0, 32'h80010000, 1'b0);
        dm_op("sw_208", 1'b1, 32'h208, 2'b11, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h208, 32'hDEADBEEF, 32'h80010000, 1'b0);
        dm_op("lbu_209", 1'b0, 32'h209, 2'b00, 1'b1, 32'h0, 4'b0000, 32'h208, 32'h0, 32'h000000BE, 1'b0);

        // Both ports requesting for 10 cycles: starvation limit and back-to-back responses
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200; dm_size = 2'b10; dm_unsigned = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_gnt%0d", i), {30'h0, if_gnt, dm_gnt}, {30'h0, pat[i]});
            if (i > 0)
                check($sformatf("starve_vld%0d", i), {30'h0, if_valid, dm_valid}, {30'h0, pat[i-1]});
            tick();
        end
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        check("starve_vld_last", {30'h0, if_valid, dm_valid}, 32'd2);
        check("starve_if_rdata", if_rdata, 32'h00A00093);

        // Reset the cycle after a fetch grant: response is discarded
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        check("rmid_gnt", {31'h0, if_gnt}, 32'd1);
        tick();
        rst = 1'b0; if_req = 1'b0;
        #1;
        check("rmid_if_valid", {31'h0, if_valid}, 32'd0);
        check("rmid_if_rdata", if_rdata, 32'd0);
        check("rmid_dm_rdata", dm_rdata, 32'd0);
        check("rmid_maddr", mem_addr, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("rmid_post_valid0", {31'h0, if_valid}, 32'd0);
        tick();
        #1;
        check("rmid_post_valid1", {31'h0, if_valid}, 32'd0);
        if_req = 1'b1; if_addr = 32'h104;
        #1;
        check("rmid_new_gnt", {31'h0, if_gnt}, 32'd1);
        tick();
        if_req = 1'b0;
        #1;
        check("rmid_new_valid", {31'h0, if_valid}, 32'd1);
        check("rmid_new_rdata", if_rdata, 32'h00B00113);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 4, maximum number of consecutive data grants while a fetch is pending (range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  fetch request; if_addr held stable until if_gnt.
REQ-005 if_addr  input  32  fetch byte address; bits [1:0] ignored.
REQ-006 if_gnt  output  1  fetch issued to memory this cycle.
REQ-007 if_valid  output  1  pulse; if_rdata valid this cycle.
REQ-008 if_rdata  output  32  fetched instruction word; held until next if_valid.
REQ-009 dm_req  input  1  data request; dm_we/dm_addr/dm_wdata/dm_size/dm_unsigned held stable until dm_gnt.
REQ-010 dm_we  input  1  1 = store, 0 = load.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  store data, right-aligned.
REQ-013 dm_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-014 dm_unsigned  input  1  load zero-extension when 1, sign-extension when 0.
REQ-015 dm_gnt  output  1  data access issued this cycle (or trapped, see REQ-031).
REQ-016 dm_valid  output  1  pulse; load data valid or store acknowledged.
REQ-017 dm_rdata  output  32  aligned, extended load data; held until next load dm_valid.
REQ-018 dm_err  output  1  pulse with dm_valid on misaligned access (config-dependent).
REQ-019 mem_addr  output  32  word-aligned address to single-port memory ([1:0] = 00).
REQ-020 mem_we  output  1  memory write strobe, issue cycle only.
REQ-021 mem_be  output  4  byte enables for writes; 0000 on reads.
REQ-022 mem_wdata  output  32  store data shifted into byte lanes.
REQ-023 mem_rdata  input  32  memory read word, valid one cycle after address (synchronous read).

Function
REQ-024 At most one access issued per cycle; a new issue is allowed in the same cycle a previous response returns (fully pipelined, throughput 1/cycle).
REQ-025 Response latency: valid pulse exactly one cycle after the corresponding gnt; mem_rdata routed to the port recorded in the outstanding-type register.
REQ-026 State register: IDLE (nothing outstanding), FETCH (fetch outstanding), DATA (data outstanding); next state set by the grant of the current cycle, IDLE if no grant.
REQ-027 Arbitration: dm_req alone -> dm; if_req alone -> if; both -> dm, unless starve count == STARVE_MAX, then if.
REQ-028 Starve counter (4 bits): increments on dm_gnt with if_req high, clears on if_gnt, never exceeds STARVE_MAX.
REQ-029 Stores: mem_be byte = 0001<<addr[1:0], half = 0011<<addr[1:0], word = 1111; mem_wdata replicated/shifted into the enabled lanes; memory written at the issue-cycle edge.
REQ-030 Loads: response word shifted right by 8*addr[1:0], then truncated to size and sign/zero extended per dm_unsigned.
REQ-031 Misaligned: half with addr[0]=1, word with addr[1:0]!=00.
REQ-032 Idle outputs: mem_we=0, mem_be=0000, mem_addr holds last value.

Reset
REQ-033 On rst low: state IDLE, starve counter 0, if_gnt/dm_gnt/if_valid/dm_valid/dm_err/mem_we 0, mem_be 0000, if_rdata/dm_rdata/mem_addr/mem_wdata 0.
REQ-034 Reset mid-operation discards the outstanding access; no valid pulse after rst deasserts for any pre-reset grant.

Configuration
REQ-035 Macro ARB_MISALIGN_TRAP_EN defined: misaligned dm access is granted but not sent to memory (mem_we=0, mem_be=0000), dm_valid and dm_err pulse the next cycle, dm_rdata unchanged.
REQ-036 Macro undefined: address low bits forced to natural alignment (half: [0]=0; word: [1:0]=00), access performed normally, dm_err tied 0.

Verification
REQ-037 if_req only, if_addr=0x100, mem holds 0x00A00093 -> if_gnt cycle N, if_valid with if_rdata=0x00A00093 at N+1.
REQ-038 Both requests held 10 cycles, STARVE_MAX=4 -> grant pattern dm,dm,dm,dm,if,dm,dm,dm,dm,if.
REQ-039 Store byte 0xAB to 0x203 then load byte signed 0x203 -> mem_be=1000, dm_rdata=0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-040 Load word at 0x202 with ARB_MISALIGN_TRAP_EN -> dm_valid+dm_err next cycle, no mem access; without macro -> reads 0x200, dm_err=0.
REQ-041 rst low in the cycle after an if_gnt -> all outputs zero, no if_valid after release, first new fetch returns correctly.
